// File: rtl/lif_pkg.sv
// Shared definitions for the LIF node readers: FSM state type and default widths.
package lif_pkg;

   // Width of a LIF node output nibble.
   localparam int unsigned LIF_OUT_W = 4;

   // Default log2 of the rate-decoder window length.
   localparam int unsigned LIF_WIN_LOG2 = 4;

   // Rate-decoder window state.
   typedef enum logic {
      StIdle,
      StAccum
   } lif_state_e;

endpackage

// File: rtl/lif_rate_window_ctr.sv
// Window sample counter: counts enabled samples and flags the one that closes the window.
module lif_rate_window_ctr #(
   parameter int unsigned WIN_LOG2 = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena_i,
   input  logic clear_i,
   output logic last_o
);

   logic [WIN_LOG2-1:0] idx_q, idx_d;

   // Advance on every enabled sample; wraps to zero after the last one.
   always_comb begin
      idx_d = idx_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (ena_i) begin
         idx_d = idx_q + WIN_LOG2'(1);
      end
   end

   // Sample index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   // clear discards a same-cycle sample, so it also suppresses the window end.
   assign last_o = ena_i & ~clear_i & (idx_q == '1);

endmodule

// File: rtl/lif_rate_decoder.sv
// Windowed rate decoder for a LIF node output: mean and nonzero count per window,
// offered on a valid/ready port with sticky overrun.
// Optional feature: define LIF_RATE_DECODER_PEAK_EN to add the res_peak output.
module lif_rate_decoder
   import lif_pkg::*;
#(
   parameter int unsigned SAMPLE_W = LIF_OUT_W,
   parameter int unsigned WIN_LOG2 = LIF_WIN_LOG2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                clear,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [SAMPLE_W-1:0] res_mean,
   output logic [WIN_LOG2:0]   res_count,
   output logic                overrun,
   output logic                busy
`ifdef LIF_RATE_DECODER_PEAK_EN
   ,
   output logic [SAMPLE_W-1:0] res_peak
`endif
);

   localparam int unsigned ACC_W = SAMPLE_W + WIN_LOG2;
   localparam int unsigned CNT_W = WIN_LOG2 + 1;

   lif_state_e state_q;

   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [CNT_W-1:0] nz_q, nz_d, nz_sum;
   logic             take;
   logic             win_end;

   logic                res_valid_q, res_valid_d;
   logic [SAMPLE_W-1:0] res_mean_q;
   logic [CNT_W-1:0]    res_count_q;
   logic                overrun_q, overrun_d;

   assign take    = ena & ~clear;
   assign acc_sum = acc_q + ACC_W'(sample);
   assign nz_sum  = nz_q + CNT_W'(|sample);

   lif_rate_window_ctr #(
      .WIN_LOG2 (WIN_LOG2)
   ) u_window_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena_i   (ena),
      .clear_i (clear),
      .last_o  (win_end)
   );

   // Window FSM: enter on the first sample, leave after the last; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else if (clear) begin
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (take) state_q <= StAccum;
            StAccum: if (win_end) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Running sum and nonzero count; both restart at window end or clear.
   always_comb begin
      acc_d = acc_q;
      nz_d  = nz_q;
      if (clear || win_end) begin
         acc_d = '0;
         nz_d  = '0;
      end else if (take) begin
         acc_d = acc_sum;
         nz_d  = nz_sum;
      end
   end

   // Result handshake: a window end always (re)loads, otherwise a transfer drops valid.
   always_comb begin
      res_valid_d = res_valid_q;
      overrun_d   = overrun_q;
      if (win_end) begin
         res_valid_d = 1'b1;
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end
      if (clear) begin
         overrun_d = 1'b0;
      end else if (win_end && res_valid_q && !res_ready) begin
         overrun_d = 1'b1;
      end
   end

   // Accumulator, handshake and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         nz_q        <= '0;
         res_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         res_mean_q  <= '0;
         res_count_q <= '0;
      end else begin
         acc_q       <= acc_d;
         nz_q        <= nz_d;
         res_valid_q <= res_valid_d;
         overrun_q   <= overrun_d;
         if (win_end) begin
            // Top SAMPLE_W bits of the sum is floor(sum / 2^WIN_LOG2).
            res_mean_q  <= acc_sum[ACC_W-1 -: SAMPLE_W];
            res_count_q <= nz_sum;
         end
      end
   end

`ifdef LIF_RATE_DECODER_PEAK_EN
   logic [SAMPLE_W-1:0] peak_q, peak_max;
   logic [SAMPLE_W-1:0] res_peak_q;

   assign peak_max = (sample > peak_q) ? sample : peak_q;

   // Running window maximum, latched into the result at window end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q     <= '0;
         res_peak_q <= '0;
      end else if (clear) begin
         peak_q <= '0;
      end else if (win_end) begin
         peak_q     <= '0;
         res_peak_q <= peak_max;
      end else if (take) begin
         peak_q <= peak_max;
      end
   end

   assign res_peak = res_peak_q;
`else
   // Peak tracking not built.
`endif

   assign res_valid = res_valid_q;
   assign res_mean  = res_mean_q;
   assign res_count = res_count_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q == StAccum);

endmodule
